// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared FSM state type and sizing constants for the sequential binary-to-BCD converter
package bin2bcd_pkg;
  localparam int MAX_IN_W = 16;
  localparam int SCRATCH_DIGITS = 5;
  localparam int CNT_W = $clog2(MAX_IN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a BCD digit of 5 or more
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adj
);
  assign adj = digit >= 4'd5 ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle
// BIN2BCD_SATURATE_EN: out-of-range operands give all-nines bcd and raise ovf
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int SW = 4 * SCRATCH_DIGITS;
  state_t state, state_n;
  logic [IN_W-1:0] sr;
  logic [SW-1:0] scratch, adj;
  logic [CNT_W-1:0] cnt;
  logic [4*DIGITS-1:0] result;
  logic load, step, finish;
  for (genvar i = 0; i < SCRATCH_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.digit(scratch[4*i +: 4]), .adj(adj[4*i +: 4]));
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    load = state == IDLE && start;
    step = state == SHIFT;
    finish = state == DONE;
    state_n = load ? SHIFT : (step && cnt == CNT_W'(1)) ? DONE : finish ? IDLE : state;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      sr <= '0;
      scratch <= '0;
      cnt <= '0;
    end else if (load) begin
      sr <= bin;
      scratch <= '0;
      cnt <= CNT_W'(IN_W);
    end else if (step) begin
      {scratch, sr} <= {adj, sr} << 1;
      cnt <= cnt - CNT_W'(1);
    end
`ifdef BIN2BCD_SATURATE_EN
  logic over;
  assign over = |scratch[SW-1:4*DIGITS];
  assign result = over ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
  always_ff @(posedge clk)
    if (rst) ovf <= 1'b0;
    else if (finish) ovf <= over;
`else
  assign result = scratch[4*DIGITS-1:0];
  assign ovf = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      done <= 1'b0;
      bcd <= '0;
    end else begin
      done <= finish;
      if (finish) bcd <= result;
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: checks 8-bit/2-digit and 16-bit/4-digit converters against an arithmetic model
module tb_bin2bcd_seq;
  logic clk = 0, rst = 1;
  logic start8 = 0, start16 = 0;
  logic [7:0] bin8 = 0;
  logic [15:0] bin16 = 0;
  logic busy8, done8, ovf8, busy16, done16, ovf16;
  logic [7:0] bcd8;
  logic [15:0] bcd16;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.IN_W(8), .DIGITS(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8));
  bin2bcd_seq #(.IN_W(16), .DIGITS(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16), .ovf(ovf16));

  function automatic logic [16:0] ref_conv(int v, int d);
    int p = 1;
    logic [15:0] b = '0;
    logic ov = 1'b0;
    for (int i = 0; i < d; i++) p *= 10;
`ifdef BIN2BCD_SATURATE_EN
    if (v >= p) begin
      ov = 1'b1;
      v = p - 1;
    end
`endif
    for (int i = 0; i < d; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v /= 10;
    end
    return {ov, b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  // Transaction model: an accepted start yields done IN_W+1 edges later
  logic m8_busy = 0, m8_done = 0, m16_busy = 0, m16_done = 0;
  logic [7:0] m8_op = 0;
  logic [15:0] m16_op = 0;
  logic [16:0] m8_res = 0, m16_res = 0;
  int m8_left = 0, m16_left = 0;

  always @(posedge clk) begin
    m8_done <= 1'b0;
    if (rst) begin
      m8_busy <= 1'b0;
      m8_left <= 0;
      m8_res <= '0;
    end else if (!m8_busy) begin
      if (start8) begin
        m8_busy <= 1'b1;
        m8_left <= 9;
        m8_op <= bin8;
      end
    end else if (m8_left == 1) begin
      m8_busy <= 1'b0;
      m8_done <= 1'b1;
      m8_res <= ref_conv(int'(m8_op), 2);
    end else m8_left <= m8_left - 1;
  end

  always @(posedge clk) begin
    m16_done <= 1'b0;
    if (rst) begin
      m16_busy <= 1'b0;
      m16_left <= 0;
      m16_res <= '0;
    end else if (!m16_busy) begin
      if (start16) begin
        m16_busy <= 1'b1;
        m16_left <= 17;
        m16_op <= bin16;
      end
    end else if (m16_left == 1) begin
      m16_busy <= 1'b0;
      m16_done <= 1'b1;
      m16_res <= ref_conv(int'(m16_op), 4);
    end else m16_left <= m16_left - 1;
  end

  always @(negedge clk) begin
    chk("dut8 busy,done,ovf,bcd", {13'b0, busy8, done8, ovf8, 8'b0, bcd8},
        {13'b0, m8_busy, m8_done, m8_res[16], 8'b0, m8_res[7:0]});
    chk("dut16 busy,done,ovf,bcd", {13'b0, busy16, done16, ovf16, bcd16},
        {13'b0, m16_busy, m16_done, m16_res[16], m16_res[15:0]});
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic go8(input logic [7:0] v);
    start8 = 1;
    bin8 = v;
    cyc();
    start8 = 0;
    bin8 = 8'($urandom);
  endtask

  task automatic go16(input logic [15:0] v);
    start16 = 1;
    bin16 = v;
    cyc();
    start16 = 0;
    bin16 = 16'($urandom);
  endtask

  task automatic wait8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait16(output int n);
    n = 0;
    while (done16 !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int n, nd;
    repeat (2) cyc();
    chk("reset busy8", 32'(busy8), 0);
    chk("reset done8", 32'(done8), 0);
    chk("reset bcd8", 32'(bcd8), 0);
    chk("reset ovf8", 32'(ovf8), 0);
    chk("reset bcd16", 32'(bcd16), 0);
    rst = 0;
    cyc();
    go8(8'd42);
    wait8(n);
    chk("latency 8b", n, 9);
    chk("bcd 42", 32'(bcd8), 32'h42);
    chk("ovf 42", 32'(ovf8), 0);
    go8(8'd99);
    wait8(n);
    chk("bcd 99", 32'(bcd8), 32'h99);
    chk("ovf 99", 32'(ovf8), 0);
    go8(8'd0);
    wait8(n);
    chk("bcd 0", 32'(bcd8), 32'h00);
    go8(8'd255);
    wait8(n);
`ifdef BIN2BCD_SATURATE_EN
    chk("bcd 255", 32'(bcd8), 32'h99);
    chk("ovf 255", 32'(ovf8), 1);
`else
    chk("bcd 255", 32'(bcd8), 32'h55);
    chk("ovf 255", 32'(ovf8), 0);
`endif
    go8(8'd7);
    cyc();
    start8 = 1;
    bin8 = 8'd63;
    cyc();
    start8 = 0;
    wait8(n);
    chk("busy start ignored", 32'(bcd8), 32'h07);
    go8(8'd63);
    wait8(n);
    chk("back-to-back latency", n, 9);
    chk("back-to-back bcd", 32'(bcd8), 32'h63);
    cyc();
    go8(8'd88);
    repeat (3) cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("abort busy", 32'(busy8), 0);
    chk("abort bcd", 32'(bcd8), 0);
    nd = 0;
    repeat (20) begin
      cyc();
      if (done8 === 1'b1) nd++;
    end
    chk("abort no done", nd, 0);
    go8(8'd12);
    wait8(n);
    chk("after abort bcd", 32'(bcd8), 32'h12);
    go16(16'd9999);
    wait16(n);
    chk("latency 16b", n, 17);
    chk("bcd 9999", 32'(bcd16), 32'h9999);
    chk("ovf 9999", 32'(ovf16), 0);
    go16(16'd65535);
    wait16(n);
`ifdef BIN2BCD_SATURATE_EN
    chk("bcd 65535", 32'(bcd16), 32'h9999);
    chk("ovf 65535", 32'(ovf16), 1);
`else
    chk("bcd 65535", 32'(bcd16), 32'h5535);
    chk("ovf 65535", 32'(ovf16), 0);
`endif
    repeat (600) begin
      cyc();
      start8 = $urandom_range(0, 2) == 0;
      bin8 = ($urandom_range(0, 3) == 0) ? 8'(99 + $urandom_range(0, 1)) : 8'($urandom);
      start16 = $urandom_range(0, 2) == 0;
      bin16 = ($urandom_range(0, 3) == 0) ? 16'(9999 + $urandom_range(0, 1)) : 16'($urandom);
      rst = $urandom_range(0, 63) == 0;
    end
    start8 = 0;
    start16 = 0;
    rst = 0;
    repeat (25) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
